// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_if
// Brief    : Line, configuration, CPU read strobe and status bundle of the
//            UART receiver.
// Revision : 1.0
// ============================================================================
interface uart_rx_if;
    logic        rx;
    logic [11:0] UBRR;
    logic [3:0]  UCSZ;
    logic [1:0]  UCR;
    logic        rd;
    logic [7:0]  UDRR;
    logic        RXC;
    logic        FE;
    logic        DOR;
    logic        PE;
    logic        busy;

    modport master (
        output rx, UBRR, UCSZ, UCR, rd,
        input  UDRR, RXC, FE, DOR, PE, busy
    );

    modport slave (
        input  rx, UBRR, UCSZ, UCR, rd,
        output UDRR, RXC, FE, DOR, PE, busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uart_receiver
// Brief    : 16x oversampling UART receiver, 5..8 data bits, one stop bit.
//            Optional even parity bit enabled by macro UART_RX_PARITY_EN.
// Revision : 1.0
// ============================================================================
module uart_receiver (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4
    } state_t;
`endif

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_rx_s1;
    logic        r_rx_s2;
    logic        r_rx_s3;
    logic [11:0] r_tick_cnt;
    logic [3:0]  r_os_cnt;
    logic [2:0]  r_bit_idx;
    logic [2:0]  r_last_idx;
    logic [7:0]  r_data;
    logic        r_stop_bit;
    logic        r_stop_done;
    logic [7:0]  r_udrr;
    logic        r_rxc;
    logic        r_fe;
    logic        r_dor;

    logic        w_en;
    logic        w_rx_fall;
    logic        w_start;
    logic        w_tick;
    logic        w_mid_start;
    logic        w_bit_end;
    logic        w_load;
    logic        w_accept;
    logic [2:0]  w_size_idx;
    logic        w_unused;

    assign w_unused    = bus.UCR[0];
    assign w_en        = bus.UCR[1];
    assign w_rx_fall   = r_rx_s3 & ~r_rx_s2;
    assign w_start     = (r_state == S_IDLE) && w_en && w_rx_fall;
    assign w_tick      = (r_tick_cnt == bus.UBRR);
    assign w_mid_start = w_tick && (r_os_cnt == 4'd7) && (r_state == S_START);
    assign w_bit_end   = w_tick && (r_os_cnt == 4'hF);
    assign w_accept    = ~r_rxc | bus.rd;

    // Index of the last data bit; out-of-range sizes clamp to 5 or 8 bits.
    always_comb begin
        w_size_idx = bus.UCSZ[2:0] - 3'd1;
        if (bus.UCSZ < 4'd5) begin
            w_size_idx = 3'd4;
        end else if (bus.UCSZ > 4'd8) begin
            w_size_idx = 3'd7;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        if (!w_en) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rx_fall) begin
                        w_state_nxt = S_START;
                    end
                end
                S_START: begin
                    if (w_mid_start) begin
                        w_state_nxt = r_rx_s2 ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_bit_end && (r_bit_idx == r_last_idx)) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        w_state_nxt = S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (r_stop_done) begin
                        w_state_nxt = S_IDLE;
                        w_load      = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_s1     <= 1'b1;
            r_rx_s2     <= 1'b1;
            r_rx_s3     <= 1'b1;
            r_tick_cnt  <= '0;
            r_os_cnt    <= '0;
            r_bit_idx   <= '0;
            r_last_idx  <= '0;
            r_data      <= '0;
            r_stop_bit  <= 1'b0;
            r_stop_done <= 1'b0;
        end else begin
            r_rx_s1 <= bus.rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;

            // A UBRR lowered below the running count restarts the divider.
            if (w_start || w_tick || (r_tick_cnt > bus.UBRR)) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + 12'd1;
            end

            if (w_start || w_mid_start) begin
                r_os_cnt <= '0;
            end else if (w_tick) begin
                r_os_cnt <= r_os_cnt + 4'd1;
            end

            if (w_start) begin
                r_bit_idx   <= '0;
                r_last_idx  <= w_size_idx;
                r_data      <= '0;
                r_stop_done <= 1'b0;
            end else if ((r_state == S_DATA) && w_bit_end) begin
                r_data[r_bit_idx] <= r_rx_s2;
                r_bit_idx         <= r_bit_idx + 3'd1;
            end else if ((r_state == S_STOP) && w_bit_end && !r_stop_done) begin
                r_stop_bit  <= r_rx_s2;
                r_stop_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_udrr <= '0;
            r_rxc  <= 1'b0;
            r_fe   <= 1'b0;
            r_dor  <= 1'b0;
        end else if (w_load) begin
            if (w_accept) begin
                r_udrr <= r_data;
                r_rxc  <= 1'b1;
                r_fe   <= ~r_stop_bit;
                r_dor  <= 1'b0;
            end else begin
                r_dor  <= 1'b1;
            end
        end else if (bus.rd) begin
            r_rxc <= 1'b0;
            r_fe  <= 1'b0;
            r_dor <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;
    logic r_pe;
    logic w_pe_new;

    // Even parity: data ones plus the parity bit must total an even count.
    assign w_pe_new = (^r_data) ^ r_par_bit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par_bit <= 1'b0;
            r_pe      <= 1'b0;
        end else begin
            if ((r_state == S_PARITY) && w_bit_end) begin
                r_par_bit <= r_rx_s2;
            end
            if (w_load) begin
                if (w_accept) begin
                    r_pe <= w_pe_new;
                end
            end else if (bus.rd) begin
                r_pe <= 1'b0;
            end
        end
    end

    assign bus.PE = r_pe;
`else
    assign bus.PE = 1'b0;
`endif

    assign bus.UDRR = r_udrr;
    assign bus.RXC  = r_rxc;
    assign bus.FE   = r_fe;
    assign bus.DOR  = r_dor;
    assign bus.busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  system clock; all state changes on the rising edge.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 rx  in  1  serial line input, asynchronous to clk, idle high.
REQ-005 UBRR  in  12  baud divider; one oversample tick every UBRR+1 clk cycles.
REQ-006 UCSZ  in  4  character size; values 5..8 are used as-is, values below 5 act as 5, values above 8 act as 8.
REQ-007 UCR  in  2  control; UCR[1] is receiver enable, UCR[0] is ignored by this block.
REQ-008 rd  in  1  one-clock strobe marking a CPU read of UDRR.
REQ-009 UDRR  out  8  received character, right-justified, unused upper bits 0.
REQ-010 RXC  out  1  receive complete: unread character present in UDRR.
REQ-011 FE  out  1  framing error: stop bit of the last loaded character sampled 0.
REQ-012 DOR  out  1  data overrun: a character completed while RXC=1.
REQ-013 PE  out  1  parity error; see Configuration.
REQ-014 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-015 rx SHALL pass through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-016 The 12-bit tick counter SHALL count 0..UBRR and emit a tick when it equals UBRR; it is cleared on start detection; one bit period is 16 ticks.
REQ-017 FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
REQ-018 IDLE -> START on a synchronized falling edge of rx while UCR[1]=1.
REQ-019 START: at tick 8, rx=1 SHALL return to IDLE (false start, no flag change); rx=0 SHALL go to DATA.
REQ-020 DATA: sample every 16 ticks, LSB first; after the configured number of bits go to PARITY if compiled in, else to STOP.
REQ-021 UCSZ SHALL be latched at start detection; changes mid-frame have no effect on the current frame.
REQ-022 STOP: sample after 16 ticks; on the next clk, return to IDLE and perform the load/flag update in REQ-023..REQ-025.
REQ-023 If RXC=0 or rd=1 in the load cycle: UDRR SHALL take the new character, RXC SHALL be 1, FE SHALL equal the inverted stop sample, and DOR SHALL be 0.
REQ-024 If RXC=1 and rd=0 in the load cycle: UDRR, FE and PE SHALL hold their values and DOR SHALL be set to 1.
REQ-025 rd=1 with no load in the same cycle SHALL clear RXC, FE, DOR and PE on the next edge.
REQ-026 Deasserting UCR[1] SHALL force IDLE on the next edge; UDRR, RXC, FE, DOR and PE SHALL be retained.
REQ-027 A frame SHALL never be accepted unless the start bit was confirmed at its mid-point.

Reset
REQ-028 While rst=0: FSM in IDLE, counters 0, synchronizer flops 1, UDRR=0x00, RXC=FE=DOR=PE=busy=0.
REQ-029 Reset asserted mid-frame SHALL discard the partial character with no flag set.

Configuration
REQ-030 Macro UART_RX_PARITY_EN defined: one even-parity bit follows the data bits in state PARITY; on load, PE SHALL equal parity mismatch, with the same load/hold rules as FE.
REQ-031 Macro UART_RX_PARITY_EN undefined: no PARITY state, no parity bit in the frame, and PE SHALL be constant 0.

Verification
REQ-032 UBRR=0, UCSZ=8, UCR=2'b10, frame 0xA5 8N1 -> UDRR=0xA5, RXC=1, FE=DOR=0; a later rd pulse sets RXC=0.
REQ-033 UCSZ=5, frame carrying data 0x1F -> UDRR=0x1F; UCSZ=2 is received as a 5-bit character.
REQ-034 A 0xA5 frame with stop bit 0 -> UDRR=0xA5, RXC=1, FE=1.
REQ-035 Frames 0x11 then 0x22 with no rd between them -> UDRR=0x11, DOR=1; rd in the load cycle of 0x22 -> UDRR=0x22, DOR=0.
REQ-036 A 4-tick low glitch on rx -> no load and no flag change; busy returns to 0 at tick 8.
REQ-037 UCR[1] cleared or rst pulsed mid-frame -> busy=0 next cycle; next clean frame 0x3C received correctly (UART_RX_PARITY_EN: odd-parity frame sets PE=1).
